ks_datapath_gen2: RTL

KS_DATAPATH_GEN2 -- requirements
Module: ks_datapath_gen2

---
 rtl/ks_datapath_gen2.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/ks_datapath_gen2.sv
// K&S datapath: IR, PC, register file, ALU and flags.
// Decodes the instruction register for the external control unit.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BOV,
    I_BNOV,
    I_BNNEG,
    I_BNZERO,
    I_HALT
  } decoded_instruction_type;
endpackage

module ks_datapath_gen2
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int REG_AW = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  logic [1:0]              operation,
  input  logic [DATA_W-1:0]       data_in,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out
);

  localparam int NREGS = 2**REG_AW;
  localparam int MSB   = DATA_W-1;

  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_zero;
  logic              r_neg;
  logic              r_uov;
  logic              r_sov;

  logic [7:0]        w_opcode;
  logic [REG_AW-1:0] w_a;
  logic [REG_AW-1:0] w_b;
  logic [REG_AW-1:0] w_c;
  logic [ADDR_W-1:0] w_mem_addr;
  decoded_instruction_type w_dec;

  logic [DATA_W-1:0] w_bus_a;
  logic [DATA_W-1:0] w_bus_b;
  logic [DATA_W-1:0] w_bus_c;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_dif;
  logic [DATA_W-1:0] w_alu;
  logic              w_uov;
  logic              w_sov;
  logic              w_unused_ir;

  assign w_opcode    = r_ir[DATA_W-1 -: 8];
  assign w_unused_ir = ^r_ir;

  // Combinational decode of the held instruction
  always_comb begin
    w_dec      = I_NOP;
    w_a        = '0;
    w_b        = '0;
    w_c        = '0;
    w_mem_addr = '0;
    unique case (1'b1)
      (w_opcode == 8'h81): begin
        w_dec      = I_LOAD;
        w_c        = r_ir[ADDR_W+REG_AW-1:ADDR_W];
        w_mem_addr = r_ir[ADDR_W-1:0];
      end
      (w_opcode == 8'h82): begin
        w_dec      = I_STORE;
        w_a        = r_ir[ADDR_W+REG_AW-1:ADDR_W];
        w_mem_addr = r_ir[ADDR_W-1:0];
      end
      (w_opcode == 8'h91): begin
        w_dec = I_MOVE;
        w_c   = r_ir[2*REG_AW-1:REG_AW];
        w_a   = r_ir[REG_AW-1:0];
        w_b   = r_ir[REG_AW-1:0];
      end
      (w_opcode == 8'hA1),
      (w_opcode == 8'hA2),
      (w_opcode == 8'hA3),
      (w_opcode == 8'hA4): begin
        w_a = r_ir[REG_AW-1:0];
        w_b = r_ir[2*REG_AW-1:REG_AW];
        w_c = r_ir[3*REG_AW-1:2*REG_AW];
        unique case (w_opcode[2:0])
          3'd1:    w_dec = I_ADD;
          3'd2:    w_dec = I_SUB;
          3'd3:    w_dec = I_AND;
          default: w_dec = I_OR;
        endcase
      end
      (w_opcode == 8'h01),
      (w_opcode == 8'h02),
      (w_opcode == 8'h03),
      (w_opcode == 8'h05),
      (w_opcode == 8'h06),
      (w_opcode == 8'h0A),
      (w_opcode == 8'h0B): begin
        w_mem_addr = r_ir[ADDR_W-1:0];
        unique case (w_opcode[3:0])
          4'h1:    w_dec = I_BRANCH;
          4'h2:    w_dec = I_BZERO;
          4'h3:    w_dec = I_BNEG;
          4'h5:    w_dec = I_BOV;
          4'h6:    w_dec = I_BNOV;
          4'hA:    w_dec = I_BNNEG;
          default: w_dec = I_BNZERO;
        endcase
      end
      (w_opcode == 8'hFF): w_dec = I_HALT;
      default: w_dec = I_NOP;
    endcase
  end

  assign w_bus_a = r_regs[w_a];
  assign w_bus_b = r_regs[w_b];
  assign w_sum   = {1'b0, w_bus_a} + {1'b0, w_bus_b};
  assign w_dif   = {1'b0, w_bus_a} - {1'b0, w_bus_b};

  // ALU result and overflow; logic ops never overflow
  always_comb begin
    w_alu = '0;
    w_uov = 1'b0;
    w_sov = 1'b0;
    unique case (operation)
      2'b00: w_alu = w_bus_a | w_bus_b;
      2'b01: begin
        w_alu = w_sum[DATA_W-1:0];
        w_uov = w_sum[DATA_W];
        w_sov = (w_bus_a[MSB] == w_bus_b[MSB]) &&
                (w_alu[MSB] != w_bus_a[MSB]);
      end
      2'b10: begin
        w_alu = w_dif[DATA_W-1:0];
        w_uov = w_dif[DATA_W];
        w_sov = (w_bus_a[MSB] != w_bus_b[MSB]) &&
                (w_alu[MSB] != w_bus_a[MSB]);
      end
      default: w_alu = w_bus_a & w_bus_b;
    endcase
  end

  assign w_bus_c = c_sel ? w_alu : data_in;

  // Instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ir <= '0;
    else if (ir_enable)
      r_ir <= data_in;
  end

  // Program counter: branch target or wrapping increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pc <= '0;
    else if (pc_enable)
      r_pc <= branch ? w_mem_addr : r_pc + ADDR_W'(1);
  end

  // Register file write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else if (write_reg_enable) begin
      r_regs[w_c] <= w_bus_c;
    end
  end

  // Flag register captures the live ALU result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_uov  <= 1'b0;
      r_sov  <= 1'b0;
    end else if (flags_reg_enable) begin
      r_zero <= (w_alu == '0);
      r_neg  <= w_alu[MSB];
      r_uov  <= w_uov;
      r_sov  <= w_sov;
    end
  end

  assign decoded_instruction = w_dec;
  assign ram_addr            = addr_sel ? r_pc : w_mem_addr;
  assign data_out            = w_bus_a;
  assign zero_op             = r_zero;
  assign neg_op              = r_neg;
  assign unsigned_overflow   = r_uov;
  assign signed_overflow     = r_sov;

endmodule
